// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: RISC-V load/store width codes,
// FSM state encoding and default sizing.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32 loads/stores: byte enables, replicated store data, extended load data.
// Purely combinational (zero latency); no flow control of its own.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] rshift;

  // Store side: the narrow datum is copied into every lane, the enables pick which land.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << byte_off;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rshift = rword >> {byte_off, 3'b000};

  always_comb begin
    rdata_ext = rword;
    case (funct3)
      F3_B:    rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
      F3_H:    rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
      F3_BU:   rdata_ext = {24'h0, rshift[7:0]};
      F3_HU:   rdata_ext = {16'h0, rshift[15:0]};
      default: rdata_ext = rword;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// RV32 data-memory slave: word RAM with byte/half/word lanes and error flagging.
// Good access responds WAIT_CYCLES+1 edges after accept, errors at the accept edge; one request in flight, no response back-pressure.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t      state;
  logic [3:0]  cnt;
  logic        q_we;
  logic [2:0]  q_funct3;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          req_err;
  logic          misaligned;
  logic          bad_funct3;
  logic          out_of_range;
  logic          do_access;
  logic [AW-1:0] word_idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   rdata_ext;
  logic          unused_addr_hi;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid & req_ready;

  // Errors are judged on the live request so they can be answered without waiting.
  assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign bad_funct3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
  assign out_of_range = (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign req_err      = misaligned | bad_funct3 | out_of_range | (req_we & req_funct3[2]);

  assign word_idx       = q_addr[AW+1:2];
  assign rword          = mem[word_idx];
  assign do_access      = (state == ST_WAIT) && (cnt == 4'd0);
  assign unused_addr_hi = ^q_addr[31:AW+2];

  dmem_lane_align u_lane_align (
    .funct3     (q_funct3),
    .byte_off   (q_addr[1:0]),
    .wdata      (q_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  // RAM is deliberately not reset; a reset during WAIT simply never reaches this write.
  always_ff @(posedge clk) begin
    if (do_access && q_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      q_we      <= 1'b0;
      q_funct3  <= 3'b000;
      q_addr    <= 32'h0;
      q_wdata   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            q_we     <= req_we;
            q_funct3 <= req_funct3;
            q_addr   <= req_addr;
            q_wdata  <= req_wdata;
            if (req_err) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= q_we ? 32'h0 : rdata_ext;
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
